// File: rtl/junction_light_ctrl.sv
// Two-road junction controller: request-driven main/side/pedestrian phase sequencing
// with fixed dwell times, all-red clearance and round-robin tie arbitration.
module junction_light_ctrl #(
    parameter int MAIN_MIN_G = 10,
    parameter int SIDE_G     = 6,
    parameter int AMBER      = 3,
    parameter int RED_AMBER  = 2,
    parameter int ALL_RED    = 2,
    parameter int WALK_T     = 8,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       side_req,
    input  logic       ped_req,
    output logic       main_red,
    output logic       main_amber,
    output logic       main_green,
    output logic       side_red,
    output logic       side_amber,
    output logic       side_green,
    output logic       walk,
    output logic [3:0] phase
);

    typedef enum logic [3:0] {
        S_ALLRED_A = 4'd0,
        S_MAIN_RA  = 4'd1,
        S_MAIN_G   = 4'd2,
        S_MAIN_A   = 4'd3,
        S_ALLRED_B = 4'd4,
        S_SIDE_RA  = 4'd5,
        S_SIDE_G   = 4'd6,
        S_SIDE_A   = 4'd7,
        S_WALK     = 4'd8
    } state_t;

    localparam logic [CNT_W-1:0] D_MAIN_G = CNT_W'(MAIN_MIN_G - 1);
    localparam logic [CNT_W-1:0] D_SIDE_G = CNT_W'(SIDE_G - 1);
    localparam logic [CNT_W-1:0] D_AMBER  = CNT_W'(AMBER - 1);
    localparam logic [CNT_W-1:0] D_RA     = CNT_W'(RED_AMBER - 1);
    localparam logic [CNT_W-1:0] D_ALLRED = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] D_WALK   = CNT_W'(WALK_T - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_side_q, pend_side_d;
    logic             pend_ped_q, pend_ped_d;
    logic             grant_q, grant_d;   // 1 = pedestrian, 0 = side road
    logic             last_q, last_d;     // winner of the most recent tie
    logic [6:0]       lamps_q, lamps_d;   // {mr, ma, mg, sr, sa, sg, walk}
    logic             done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_ALLRED_A;
            cnt_q       <= D_ALLRED;
            pend_side_q <= 1'b0;
            pend_ped_q  <= 1'b0;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            lamps_q     <= 7'b1001000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_side_q <= pend_side_d;
            pend_ped_q  <= pend_ped_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            lamps_q     <= lamps_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        last_d      = last_q;
        pend_side_d = pend_side_q;
        pend_ped_d  = pend_ped_q;
        lamps_d     = 7'b1001000;
        done        = (cnt_q == '0);

        // Counter holds at zero, which gives the open-ended main-green wait.
        if (!done) cnt_d = cnt_q - CNT_W'(1);

        case (state_q)
            S_ALLRED_A: if (done) begin state_d = S_MAIN_RA;  cnt_d = D_RA;     end
            S_MAIN_RA:  if (done) begin state_d = S_MAIN_G;   cnt_d = D_MAIN_G; end
            S_MAIN_G: begin
                if (done && (pend_side_q || pend_ped_q)) begin
                    state_d = S_MAIN_A;
                    cnt_d   = D_AMBER;
                    if (pend_side_q && pend_ped_q) begin
                        grant_d = ~last_q;
                        last_d  = ~last_q;
                    end else begin
                        grant_d = pend_ped_q;
                    end
                end
            end
            S_MAIN_A:   if (done) begin state_d = S_ALLRED_B; cnt_d = D_ALLRED; end
            S_ALLRED_B: begin
                if (done) begin
                    state_d = grant_q ? S_WALK : S_SIDE_RA;
                    cnt_d   = grant_q ? D_WALK : D_RA;
                end
            end
            S_SIDE_RA:  if (done) begin state_d = S_SIDE_G;   cnt_d = D_SIDE_G; end
            S_SIDE_G:   if (done) begin state_d = S_SIDE_A;   cnt_d = D_AMBER;  end
            S_SIDE_A:   if (done) begin state_d = S_ALLRED_A; cnt_d = D_ALLRED; end
            S_WALK:     if (done) begin state_d = S_ALLRED_A; cnt_d = D_ALLRED; end
            default: begin
                state_d = S_ALLRED_A;
                cnt_d   = D_ALLRED;
            end
        endcase

        // Clearing on entry to the served phase takes priority over a new request.
        if (state_d == S_SIDE_RA && state_q != S_SIDE_RA)
            pend_side_d = 1'b0;
        else if (side_req && state_q != S_SIDE_RA && state_q != S_SIDE_G)
            pend_side_d = 1'b1;

        if (state_d == S_WALK && state_q != S_WALK)
            pend_ped_d = 1'b0;
        else if (ped_req && state_q != S_WALK)
            pend_ped_d = 1'b1;

        case (state_d)
            S_ALLRED_A, S_ALLRED_B: lamps_d = 7'b1001000;
            S_MAIN_RA:              lamps_d = 7'b1101000;
            S_MAIN_G:               lamps_d = 7'b0011000;
            S_MAIN_A:               lamps_d = 7'b0101000;
            S_SIDE_RA:              lamps_d = 7'b1001100;
            S_SIDE_G:               lamps_d = 7'b1000010;
            S_SIDE_A:               lamps_d = 7'b1000100;
            S_WALK:                 lamps_d = 7'b1001001;
            default:                lamps_d = 7'b1001000;
        endcase
    end

    assign {main_red, main_amber, main_green, side_red, side_amber, side_green, walk} = lamps_q;
    assign phase = state_q;

endmodule

// File: tb/tb_junction_light_ctrl.sv
// Directed table-driven bench for junction_light_ctrl: per-cycle phase/lamp checks
// plus a bounded hand-written pedestrian-latency sequence.
module tb_junction_light_ctrl;

    logic       clk;
    logic       rst;
    logic       side_req;
    logic       ped_req;
    logic       main_red, main_amber, main_green;
    logic       side_red, side_amber, side_green;
    logic       walk;
    logic [3:0] phase;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    junction_light_ctrl #(
        .MAIN_MIN_G(10),
        .SIDE_G    (6),
        .AMBER     (3),
        .RED_AMBER (2),
        .ALL_RED   (2),
        .WALK_T    (8),
        .CNT_W     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .side_req  (side_req),
        .ped_req   (ped_req),
        .main_red  (main_red),
        .main_amber(main_amber),
        .main_green(main_green),
        .side_red  (side_red),
        .side_amber(side_amber),
        .side_green(side_green),
        .walk      (walk),
        .phase     (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        side;
        logic        ped;
        int unsigned n;
        logic [3:0]  ph;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic s, input logic p,
                       input int unsigned n, input logic [3:0] ph);
        vec_t v;
        v.rst = r; v.side = s; v.ped = p; v.n = n; v.ph = ph;
        tbl.push_back(v);
    endtask

    // Expected lamps {mr, ma, mg, sr, sa, sg, walk} for each phase code.
    function automatic logic [6:0] lamps_for(input logic [3:0] ph);
        case (ph)
            4'd0, 4'd4: return 7'b1001000;
            4'd1:       return 7'b1101000;
            4'd2:       return 7'b0011000;
            4'd3:       return 7'b0101000;
            4'd5:       return 7'b1001100;
            4'd6:       return 7'b1000010;
            4'd7:       return 7'b1000100;
            4'd8:       return 7'b1001001;
            default:    return 7'b0000000;
        endcase
    endfunction

    task automatic check_cycle(input int unsigned rec, input logic [3:0] exp_ph);
        logic [6:0] got;
        logic       conflict;
        got = {main_red, main_amber, main_green, side_red, side_amber, side_green, walk};
        n_vec++;
        if (phase !== exp_ph) begin
            n_bad++;
            $display("FAIL phase rec %0d t=%0t: got %0d want %0d", rec, $time, phase, exp_ph);
        end
        n_vec++;
        if (got !== lamps_for(exp_ph)) begin
            n_bad++;
            $display("FAIL lamps rec %0d t=%0t: got %b want %b", rec, $time, got, lamps_for(exp_ph));
        end
        conflict = (main_green && !side_red) || (side_green && !main_red);
        n_vec++;
        if (conflict !== 1'b0) begin
            n_bad++;
            $display("FAIL green_conflict rec %0d t=%0t: got %b want 0", rec, $time, conflict);
        end
    endtask

    task automatic power_up(input logic s, input logic p);
        add(1, 0, 0, 1, 0);
        add(0, s, p, 1, 0);
        add(0, s, p, 2, 1);
    endtask

    initial begin
        int unsigned cyc;
        int unsigned w;

        rst = 1'b1; side_req = 1'b0; ped_req = 1'b0;

        // Idle after reset: main green holds with no requests.
        power_up(0, 0);
        add(0, 0, 0, 105, 2);

        // Side pulse in main green; side requests during SIDE_RA/SIDE_G are ignored.
        power_up(0, 0);
        add(0, 0, 0, 2, 2);
        add(0, 1, 0, 1, 2);
        add(0, 0, 0, 7, 2);
        add(0, 0, 0, 3, 3);
        add(0, 0, 0, 2, 4);
        add(0, 0, 0, 1, 5);
        add(0, 1, 0, 1, 5);
        add(0, 1, 0, 6, 6);
        add(0, 0, 0, 3, 7);
        add(0, 0, 0, 2, 0);
        add(0, 0, 0, 2, 1);
        add(0, 0, 0, 30, 2);

        // Both pulsed together: side first, then walk; ped during WALK ignored.
        power_up(0, 0);
        add(0, 0, 0, 2, 2);
        add(0, 1, 1, 1, 2);
        add(0, 0, 0, 7, 2);
        add(0, 0, 0, 3, 3);
        add(0, 0, 0, 2, 4);
        add(0, 0, 0, 2, 5);
        add(0, 0, 0, 6, 6);
        add(0, 0, 0, 3, 7);
        add(0, 0, 0, 2, 0);
        add(0, 0, 0, 2, 1);
        add(0, 0, 0, 10, 2);
        add(0, 0, 0, 3, 3);
        add(0, 0, 0, 2, 4);
        add(0, 0, 0, 2, 8);
        add(0, 0, 1, 3, 8);
        add(0, 0, 0, 3, 8);
        add(0, 0, 0, 2, 0);
        add(0, 0, 0, 2, 1);
        add(0, 0, 0, 30, 2);

        // Ped pulse during SIDE_A is latched and served after the next minimum green.
        power_up(0, 0);
        add(0, 0, 0, 2, 2);
        add(0, 1, 0, 1, 2);
        add(0, 0, 0, 7, 2);
        add(0, 0, 0, 3, 3);
        add(0, 0, 0, 2, 4);
        add(0, 0, 0, 2, 5);
        add(0, 0, 0, 6, 6);
        add(0, 0, 0, 1, 7);
        add(0, 0, 1, 1, 7);
        add(0, 0, 0, 1, 7);
        add(0, 0, 0, 2, 0);
        add(0, 0, 0, 2, 1);
        add(0, 0, 0, 10, 2);
        add(0, 0, 0, 3, 3);
        add(0, 0, 0, 2, 4);
        add(0, 0, 0, 8, 8);
        add(0, 0, 0, 2, 0);
        add(0, 0, 0, 2, 1);
        add(0, 0, 0, 15, 2);

        // Both held high: side, ped, side, ped.
        power_up(1, 1);
        for (int k = 0; k < 2; k++) begin
            add(1'b0, 1'b1, 1'b1, 10, 2);
            add(1'b0, 1'b1, 1'b1, 3, 3);
            add(1'b0, 1'b1, 1'b1, 2, 4);
            add(1'b0, 1'b1, 1'b1, 2, 5);
            add(1'b0, 1'b1, 1'b1, 6, 6);
            add(1'b0, 1'b1, 1'b1, 3, 7);
            add(1'b0, 1'b1, 1'b1, 2, 0);
            add(1'b0, 1'b1, 1'b1, 2, 1);
            add(1'b0, 1'b1, 1'b1, 10, 2);
            add(1'b0, 1'b1, 1'b1, 3, 3);
            add(1'b0, 1'b1, 1'b1, 2, 4);
            add(1'b0, 1'b1, 1'b1, 8, 8);
            if (k == 0) begin
                add(1'b0, 1'b1, 1'b1, 2, 0);
                add(1'b0, 1'b1, 1'b1, 2, 1);
            end
        end

        // Reset mid SIDE_G with a ped request pending: aborts and clears pending.
        power_up(0, 0);
        add(0, 0, 0, 2, 2);
        add(0, 1, 0, 1, 2);
        add(0, 0, 0, 7, 2);
        add(0, 0, 0, 3, 3);
        add(0, 0, 0, 2, 4);
        add(0, 0, 1, 2, 5);
        add(0, 0, 0, 3, 6);
        add(1, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0);
        add(0, 0, 0, 2, 1);
        add(0, 0, 0, 25, 2);

        for (int unsigned r = 0; r < tbl.size(); r++) begin
            for (int unsigned c = 0; c < tbl[r].n; c++) begin
                rst      = tbl[r].rst;
                side_req = tbl[r].side;
                ped_req  = tbl[r].ped;
                @(posedge clk);
                #1;
                check_cycle(r, tbl[r].ph);
            end
        end

        // Hand-written: ped pulse right after reset reaches WALK 19 edges after reset.
        rst = 1'b1; side_req = 1'b0; ped_req = 1'b0;
        @(posedge clk);
        #1;
        check_cycle(9999, 4'd0);
        rst = 1'b0; ped_req = 1'b1;
        @(posedge clk);
        #1;
        ped_req = 1'b0;
        cyc = 1;
        while (phase != 4'd8 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_vec++;
        if (cyc != 19) begin
            n_bad++;
            $display("FAIL walk_latency: got %0d edges want 19", cyc);
        end
        w = 0;
        while (phase == 4'd8 && w < 20) begin
            check_cycle(10000, 4'd8);
            @(posedge clk);
            #1;
            w++;
        end
        n_vec++;
        if (w != 8) begin
            n_bad++;
            $display("FAIL walk_length: got %0d cycles want 8", w);
        end
        check_cycle(10001, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
